// File: rtl/accu_pkg.sv
// Shared definitions for the partial-sum accumulation sequencer:
// data width, FSM state encoding and the saturating add helper.
package accu_pkg;

    localparam int DATA_W = 18;

    // FSM state encoding, also visible on the controller's debug state output
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Signed add one bit wider than the operands, clamped back to DATA_W
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? SAT_MIN : SAT_MAX;
        end
        return s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/accu_fifo_ctrl_if.sv
// Bus between the accumulation sequencer (master) and the partial-sum FIFO (slave).
// Handshake: fifo_rd_en pops one entry, whose value appears on fifo_rd_data the
// following cycle; fifo_wr_en pushes fifo_wr_data in the same cycle. There is no
// backpressure: the flags are advisory and misuse is reported by the master's err.
interface accu_fifo_ctrl_if;
    import accu_pkg::*;

    logic                     fifo_clr;
    logic                     fifo_rd_en;
    logic                     fifo_wr_en;
    logic signed [DATA_W-1:0] fifo_wr_data;
    logic signed [DATA_W-1:0] fifo_rd_data;
    logic                     fifo_empty;
    logic                     fifo_full;

    modport master (
        output fifo_clr, fifo_rd_en, fifo_wr_en, fifo_wr_data,
        input  fifo_rd_data, fifo_empty, fifo_full
    );

    modport slave (
        input  fifo_clr, fifo_rd_en, fifo_wr_en, fifo_wr_data,
        output fifo_rd_data, fifo_empty, fifo_full
    );

endinterface

// File: rtl/accu_sat_add.sv
// Combinational DATA_W signed saturating adder used by stage 1 of the sequencer.
module accu_sat_add
    import accu_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] sum
);

    assign sum = sat_add(a, b);

endmodule

// File: rtl/accu_fifo_ctrl.sv
// Partial-sum accumulation sequencer. One pass per input channel: pass 0 writes raw
// products to the FIFO, middle passes pop, add and push back, the final pass pops,
// adds and emits on dout. din -> dout / FIFO write latency is two cycles.
// valid_in qualifies din; there is no ready, so the PE array may insert gaps freely.
module accu_fifo_ctrl
    import accu_pkg::*;
#(
    parameter int LEN_W = 12,
    parameter int CH_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] din,
    accu_fifo_ctrl_if.master         fifo,
    output logic                     valid_out,
    output logic signed [DATA_W-1:0] dout,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               state
);

    logic [1:0]               state_q;
    logic [LEN_W-1:0]         len_q, pix_cnt;
    logic [CH_W-1:0]          ch_q, ch_cnt;
    logic                     s1_v, s1_first, s1_last;
    logic signed [DATA_W-1:0] s1_din, s1_addend, sum;
    logic                     accept, run_in, pix_wrap, last_pass;

    assign accept    = (state_q == ST_IDLE) && start;
    assign run_in    = (state_q == ST_RUN) && valid_in;
    assign pix_wrap  = (pix_cnt == len_q - LEN_W'(1));
    assign last_pass = (ch_cnt == ch_q - CH_W'(1));

    // Pass 0 has nothing to read back; every later pass pops one entry per pixel
    assign fifo.fifo_rd_en = run_in && (ch_cnt != '0);

    assign busy  = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done  = (state_q == ST_DONE);
    assign state = state_q;

    // FSM plus config latch and pixel/channel counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            ch_q    <= '0;
            pix_cnt <= '0;
            ch_cnt  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        len_q   <= cfg_len;
                        ch_q    <= cfg_ch;
                        pix_cnt <= '0;
                        ch_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (valid_in) begin
                        if (pix_wrap) begin
                            pix_cnt <= '0;
                            if (last_pass) begin
                                state_q <= ST_FLUSH;
                            end else begin
                                ch_cnt <= ch_cnt + CH_W'(1);
                            end
                        end else begin
                            pix_cnt <= pix_cnt + LEN_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    // Outputs register on the same edge stage 1 drains
                    if (!s1_v) begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage 0 -> 1: capture the accepted pixel and its pass position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_din   <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_v <= run_in;
            if (run_in) begin
                s1_din   <= din;
                s1_first <= (ch_cnt == '0);
                s1_last  <= last_pass;
            end
        end
    end

    // First pass adds zero, so raw products go through the adder unchanged
    assign s1_addend = s1_first ? '0 : fifo.fifo_rd_data;

    accu_sat_add u_add (
        .a   (s1_din),
        .b   (s1_addend),
        .sum (sum)
    );

    // Stage 1 -> outputs: final pass goes to dout, others back into the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out         <= 1'b0;
            dout              <= '0;
            fifo.fifo_wr_en   <= 1'b0;
            fifo.fifo_wr_data <= '0;
        end else begin
            valid_out       <= s1_v && s1_last;
            fifo.fifo_wr_en <= s1_v && !s1_last;
            if (s1_v && s1_last) begin
                dout <= sum;
            end
            if (s1_v && !s1_last) begin
                fifo.fifo_wr_data <= sum;
            end
        end
    end

    // FIFO flush pulse on accepted start and sticky misuse flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo.fifo_clr <= 1'b0;
            err           <= 1'b0;
        end else begin
            fifo.fifo_clr <= accept;
            if (accept) begin
                err <= 1'b0;
            end else if ((fifo.fifo_rd_en && fifo.fifo_empty) ||
                         (fifo.fifo_wr_en && fifo.fifo_full)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accu_fifo_ctrl.sv
// Directed bench for accu_fifo_ctrl with a behavioural FIFO and a dout scoreboard.
module tb_accu_fifo_ctrl;

    localparam int DW    = 18;
    localparam int DEPTH = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [11:0]          cfg_len;
    logic [7:0]           cfg_ch;
    logic                 valid_in;
    logic signed [DW-1:0] din;
    logic                 valid_out;
    logic signed [DW-1:0] dout;
    logic                 busy, done, err;
    logic [1:0]           state;

    accu_fifo_ctrl_if fifo_bus ();

    accu_fifo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_ch    (cfg_ch),
        .valid_in  (valid_in),
        .din       (din),
        .fifo      (fifo_bus),
        .valid_out (valid_out),
        .dout      (dout),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state     (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural FIFO ----------------
    logic [DW-1:0] fq[$];
    int            fcount = 0;
    logic          force_empty = 1'b0;

    assign fifo_bus.fifo_empty = force_empty || (fcount == 0);
    assign fifo_bus.fifo_full  = (fcount >= DEPTH);

    always @(posedge clk) begin
        if (fifo_bus.fifo_clr) begin
            fq.delete();
        end else begin
            if (fifo_bus.fifo_rd_en) begin
                if (fq.size() > 0) fifo_bus.fifo_rd_data <= fq.pop_front();
                else               fifo_bus.fifo_rd_data <= '0;
            end
            if (fifo_bus.fifo_wr_en) fq.push_back(fifo_bus.fifo_wr_data);
        end
        fcount <= fq.size();
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    int lat_q[$];
    int rd_cnt = 0, wr_cnt = 0, last_vo_cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: count FIFO traffic and score every dout against the queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_bus.fifo_wr_en) wr_cnt++;
            if (fifo_bus.fifo_rd_en) rd_cnt++;
            if (valid_out) begin
                last_vo_cyc = cyc;
                if (exp_q.size() == 0) check("unexpected_valid_out", int'(valid_out), 0);
                else                   check("dout", int'(dout), int'(signed'(exp_q.pop_front())));
                if (lat_q.size() > 0)  check("latency", cyc - lat_q.pop_front(), 2);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input int len, input int ch);
        @(posedge clk); #1;
        start = 1'b1; cfg_len = 12'(len); cfg_ch = 8'(ch); valid_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("clr_pulse", int'(fifo_bus.fifo_clr), 1);
        check("busy_after_start", int'(busy), 1);
        check("err_cleared", int'(err), 0);
    endtask

    task automatic drive(input int v, input bit rec);
        @(posedge clk); #1;
        valid_in = 1'b1; din = DW'(v);
        if (rec) lat_q.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b0; din = DW'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_done(input bit chk_gap);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", int'(done), 1);
        if (chk_gap) check("done_gap", cyc - last_vo_cyc, 1);
        check("busy_at_done", int'(busy), 0);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("state_idle", int'(state), 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_ch = '0;
        valid_in = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_wr_en", int'(fifo_bus.fifo_wr_en), 0);
        check("rst_clr", int'(fifo_bus.fifo_clr), 0);
        check("rst_state", int'(state), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: len=4 ch=3, 1..4 each pass -> 3,6,9,12; a start while busy is ignored
        clear_counts();
        exp_q = '{3, 6, 9, 12};
        do_start(4, 3);
        for (int p = 0; p < 3; p++) begin
            for (int i = 1; i <= 4; i++) drive(i, p == 2);
            if (p == 0) begin
                @(posedge clk); #1;
                valid_in = 1'b0; start = 1'b1; cfg_len = 12'd1; cfg_ch = 8'd1;
                @(posedge clk); #1 start = 1'b0;
                @(negedge clk);
                check("start_while_busy_clr", int'(fifo_bus.fifo_clr), 0);
            end
        end
        idle(1);
        wait_done(1'b1);
        check("t1_wr_cnt", wr_cnt, 8);
        check("t1_rd_cnt", rd_cnt, 8);
        check("t1_err", int'(err), 0);

        // 2: single channel pass-through, FIFO untouched
        clear_counts();
        exp_q = '{10, 11, 12, 13, 14};
        do_start(5, 1);
        for (int i = 10; i <= 14; i++) drive(i, 1'b1);
        idle(1);
        wait_done(1'b1);
        check("t2_wr_cnt", wr_cnt, 0);
        check("t2_rd_cnt", rd_cnt, 0);

        // 3: saturation at both rails
        exp_q = '{131071, 131071};
        do_start(2, 2);
        drive(131071, 1'b0); drive(131071, 1'b0); idle(2);
        drive(131071, 1'b1); drive(131071, 1'b1); idle(1);
        wait_done(1'b1);
        exp_q = '{DW'(-131072), DW'(-131072)};
        do_start(2, 2);
        drive(-131072, 1'b0); drive(-131072, 1'b0); idle(2);
        drive(-131072, 1'b1); drive(-131072, 1'b1); idle(1);
        wait_done(1'b1);
        check("t3_err", int'(err), 0);

        // 4: gaps of 1-3 cycles between pixels; sums 5+20, -7+30, 100-40
        clear_counts();
        exp_q = '{25, 23, 60};
        do_start(3, 2);
        foreach (exp_q[i]) begin end
        drive(5, 1'b0);   idle($urandom_range(1, 3));
        drive(-7, 1'b0);  idle($urandom_range(1, 3));
        drive(100, 1'b0); idle($urandom_range(1, 3));
        drive(20, 1'b1);  idle($urandom_range(1, 3));
        drive(30, 1'b1);  idle($urandom_range(1, 3));
        drive(-40, 1'b1); idle(1);
        wait_done(1'b1);
        check("t4_wr_cnt", wr_cnt, 3);
        check("t4_rd_cnt", rd_cnt, 3);

        // 5: empty flag forced during pass 1 -> sticky err, cleared by next start
        exp_q = '{4, 6};
        do_start(2, 2);
        drive(1, 1'b0); drive(2, 1'b0); idle(2);
        force_empty = 1'b1;
        drive(3, 1'b1); drive(4, 1'b1); idle(1);
        force_empty = 1'b0;
        @(negedge clk);
        check("t5_err_set", int'(err), 1);
        wait_done(1'b1);
        repeat (3) @(negedge clk);
        check("t5_err_held", int'(err), 1);
        exp_q = '{7};
        do_start(1, 1);
        drive(7, 1'b1); idle(1);
        wait_done(1'b1);
        check("t5_err_after", int'(err), 0);

        // 6: reset in the middle of pass 1, then valid_in without start
        do_start(4, 3);
        for (int i = 0; i < 4; i++) drive(i + 1, 1'b0);
        drive(9, 1'b0); drive(9, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("t6_busy", int'(busy), 0);
        check("t6_state", int'(state), 0);
        check("t6_rd_en", int'(fifo_bus.fifo_rd_en), 0);
        check("t6_wr_en", int'(fifo_bus.fifo_wr_en), 0);
        check("t6_valid_out", int'(valid_out), 0);
        check("t6_dout", int'(dout), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_counts();
        for (int i = 0; i < 4; i++) drive($urandom_range(1, 100), 1'b0);
        idle(3);
        @(negedge clk);
        check("t6_ignored_busy", int'(busy), 0);
        check("t6_ignored_state", int'(state), 0);
        check("t6_ignored_wr", wr_cnt, 0);
        check("t6_ignored_rd", rd_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
